// File: rtl/uart_bram_streamer_if.sv
// Signal bundle for uart_bram_streamer: frame control, BRAM read port and UART transmitter port.
// The slave modport is the streamer's view; the master modport is the surrounding system's view.
interface uart_bram_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 13
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] bram_addr_o;
  logic [7:0]            bram_data_i;
  logic [7:0]            tx_data_o;
  logic                  tx_start_o;
  logic                  tx_done_i;

  modport slave (
    input  start_i, base_addr_i, len_i, bram_data_i, tx_done_i,
    output busy_o, done_o, bram_addr_o, tx_data_o, tx_start_o
  );

  modport master (
    output start_i, base_addr_i, len_i, bram_data_i, tx_done_i,
    input  busy_o, done_o, bram_addr_o, tx_data_o, tx_start_o
  );
endinterface

// File: rtl/uart_bram_streamer.sv
// Streams a BRAM region to a byte-wide UART transmitter as a frame: header byte, then payload.
// Define STREAM_CHECKSUM_EN to append a running XOR of the payload bytes before the frame ends.
module uart_bram_streamer #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned LEN_WIDTH    = 13,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_i,
  uart_bram_streamer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    WAIT_HDR,
    FETCH,
    WAIT_RD,
    SEND_BYTE,
    WAIT_TX,
`ifdef STREAM_CHECKSUM_EN
    SEND_CK,
    WAIT_CK,
`endif
    FINISH
  } state_t;

`ifdef STREAM_CHECKSUM_EN
  localparam state_t TAIL = SEND_CK;
`else
  localparam state_t TAIL = FINISH;
`endif

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [LEN_WIDTH-1:0]  count_inc;
  logic [2:0]            lat_q;
  logic [7:0]            data_q;
`ifdef STREAM_CHECKSUM_EN
  logic [7:0]            ck_q;
`endif
  logic                  rd_last;
  logic                  more;
  logic                  busy;
  logic                  done;
  logic                  tx_start;

  // count < len always holds while a byte is outstanding, so count+1 never exceeds len.
  assign count_inc = count_q + LEN_WIDTH'(1);
  assign more      = (count_inc < len_q);
  assign rd_last   = (lat_q == 3'(BRAM_LATENCY));

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start_i) state_next = SEND_HDR;
      end
      SEND_HDR: begin
        tx_start   = 1'b1;
        state_next = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (bus.tx_done_i) state_next = (len_q != '0) ? FETCH : TAIL;
      end
      FETCH: begin
        state_next = WAIT_RD;
      end
      WAIT_RD: begin
        if (rd_last) state_next = SEND_BYTE;
      end
      SEND_BYTE: begin
        tx_start   = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done_i) state_next = more ? FETCH : TAIL;
      end
`ifdef STREAM_CHECKSUM_EN
      SEND_CK: begin
        tx_start   = 1'b1;
        state_next = WAIT_CK;
      end
      WAIT_CK: begin
        if (bus.tx_done_i) state_next = FINISH;
      end
`endif
      FINISH: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // The next BRAM address is registered on entry to FETCH so it is stable through WAIT_RD.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      lat_q   <= '0;
`ifdef STREAM_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            base_q  <= bus.base_addr_i;
            len_q   <= bus.len_i;
            count_q <= '0;
            data_q  <= HEADER_BYTE;
`ifdef STREAM_CHECKSUM_EN
            ck_q    <= '0;
`endif
          end
        end
        WAIT_HDR: begin
          if (bus.tx_done_i) begin
            if (len_q != '0) begin
              addr_q <= base_q;
            end
`ifdef STREAM_CHECKSUM_EN
            else begin
              data_q <= ck_q;
            end
`endif
          end
        end
        FETCH: begin
          lat_q <= 3'd1;
        end
        WAIT_RD: begin
          if (rd_last) begin
            data_q <= bus.bram_data_i;
`ifdef STREAM_CHECKSUM_EN
            ck_q   <= ck_q ^ bus.bram_data_i;
`endif
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        WAIT_TX: begin
          if (bus.tx_done_i) begin
            count_q <= count_inc;
            if (more) begin
              addr_q <= base_q + ADDR_WIDTH'(count_inc);
            end
`ifdef STREAM_CHECKSUM_EN
            else begin
              data_q <= ck_q;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.tx_start_o  = tx_start;
  assign bus.tx_data_o   = data_q;
  assign bus.bram_addr_o = addr_q;

endmodule

// File: tb/tb_uart_bram_streamer.sv
// Directed bench for uart_bram_streamer: BRAM latency 2 instance with an auto-responding UART
// model, plus latency 1 and 4 instances driven by hand for timing checks.
module tb_uart_bram_streamer;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = 13;
  localparam int RESP_DELAY = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_bram_streamer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
  uart_bram_streamer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus1 ();
  uart_bram_streamer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus4 ();

  uart_bram_streamer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BRAM_LATENCY(2), .HEADER_BYTE(8'hA5))
    dut (.clk(clk), .rst_i(rst), .bus(bus));
  uart_bram_streamer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BRAM_LATENCY(1), .HEADER_BYTE(8'hA5))
    dut_l1 (.clk(clk), .rst_i(rst), .bus(bus1));
  uart_bram_streamer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BRAM_LATENCY(4), .HEADER_BYTE(8'hA5))
    dut_l4 (.clk(clk), .rst_i(rst), .bus(bus4));

  // Main BRAM model: two register stages
  logic [7:0] mem [0:4095];
  logic [7:0] m_p1, m_p2;
  always @(posedge clk) begin
    m_p1 <= mem[bus.bram_addr_o];
    m_p2 <= m_p1;
  end
  assign bus.bram_data_i = m_p2;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  logic [7:0] x1_d;
  logic [7:0] x4_p [4];
  always @(posedge clk) begin
    x1_d     <= pat(bus1.bram_addr_o);
    x4_p[0]  <= pat(bus4.bram_addr_o);
    for (int i = 1; i < 4; i++) x4_p[i] <= x4_p[i-1];
  end
  assign bus1.bram_data_i = x1_d;
  assign bus4.bram_data_i = x4_p[3];

  logic          x_start = 1'b0;
  logic          x_done  = 1'b0;
  logic [AW-1:0] x_base  = '0;
  logic [LW-1:0] x_len   = '0;
  assign bus1.start_i     = x_start;
  assign bus1.base_addr_i = x_base;
  assign bus1.len_i       = x_len;
  assign bus1.tx_done_i   = x_done;
  assign bus4.start_i     = x_start;
  assign bus4.base_addr_i = x_base;
  assign bus4.len_i       = x_len;
  assign bus4.tx_done_i   = x_done;

  // UART transmitter model for the main instance
  logic [7:0]    rx_q [$];
  logic [AW-1:0] addr_q [$];
  bit            pending = 0;
  int            remaining = 0;
  logic [7:0]    held = '0;
  int            overlap_err = 0;
  int            hold_err = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            txdone_cyc = 0;
  logic          busy_at_done = 1'b0;

  initial begin
    bus.tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done_i = 1'b0;
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = bus.busy_o;
      end
      if (bus.tx_start_o === 1'b1) begin
        if (pending) overlap_err++;
        rx_q.push_back(bus.tx_data_o);
        addr_q.push_back(bus.bram_addr_o);
        held      = bus.tx_data_o;
        pending   = 1;
        remaining = RESP_DELAY;
      end else if (pending) begin
        if (bus.tx_data_o !== held) hold_err++;
        remaining--;
        if (remaining == 0) begin
          bus.tx_done_i = 1'b1;
          pending       = 0;
          txdone_cyc    = cyc;
        end
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] base, input logic [LW-1:0] len);
    @(negedge clk);
    bus.base_addr_i = base;
    bus.len_i       = len;
    bus.start_i     = 1'b1;
    @(negedge clk);
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.tx_start_o !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start_o); end
    checks++; if (bus.tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data_o); end
    checks++; if (bus.bram_addr_o !== 12'h000) begin errors++; $display("FAIL reset_bram_addr: got %h want 000", bus.bram_addr_o); end
  endtask

  task automatic test_basic();
    logic [7:0]    exp_b [$];
    logic [AW-1:0] exp_a [$];
    int d0;
    bit ok;
    exp_b = {8'hA5, 8'h54, 8'hFF, 8'h01};
`ifdef STREAM_CHECKSUM_EN
    exp_b.push_back(8'hAA);
`endif
    exp_a = {12'h010, 12'h011, 12'h012};
    rx_q.delete();
    addr_q.delete();
    d0 = done_cnt;
    start_frame(12'h010, 13'd3);
    checks++; if (bus.tx_start_o !== 1'b1) begin errors++; $display("FAIL basic_hdr_start: got %b want 1", bus.tx_start_o); end
    checks++; if (bus.tx_data_o !== 8'hA5) begin errors++; $display("FAIL basic_hdr_data: got %h want a5", bus.tx_data_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy_o); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got none want done_o"); end
    checks++; if (rx_q.size() != exp_b.size()) begin errors++; $display("FAIL basic_len: got %0d want %0d", rx_q.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    for (int i = 0; i < exp_a.size() && i + 1 < addr_q.size(); i++) begin
      checks++; if (addr_q[i+1] !== exp_a[i]) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_q[i+1], exp_a[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
    checks++; if (overlap_err != 0) begin errors++; $display("FAIL basic_overlap: got %0d want 0", overlap_err); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL basic_hold: got %0d want 0", hold_err); end
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done_o); end
  endtask

  task automatic test_len_zero();
    logic [7:0] exp_b [$];
    bit ok;
    exp_b = {8'hA5};
`ifdef STREAM_CHECKSUM_EN
    exp_b.push_back(8'h00);
`endif
    rx_q.delete();
    start_frame(12'h200, 13'd0);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout: got none want done_o"); end
    checks++; if (rx_q.size() != exp_b.size()) begin errors++; $display("FAIL zero_len: got %0d want %0d", rx_q.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL zero_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    checks++; if (done_cyc - txdone_cyc != 1) begin errors++; $display("FAIL zero_done_latency: got %0d want 1", done_cyc - txdone_cyc); end
  endtask

  task automatic test_wrap();
    logic [7:0]    exp_b [$];
    logic [AW-1:0] exp_a [$];
    bit ok;
    exp_b = {8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef STREAM_CHECKSUM_EN
    exp_b.push_back(8'h44);
`endif
    exp_a = {12'hFFE, 12'hFFF, 12'h000, 12'h001};
    rx_q.delete();
    addr_q.delete();
    start_frame(12'hFFE, 13'd4);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: got none want done_o"); end
    checks++; if (rx_q.size() != exp_b.size()) begin errors++; $display("FAIL wrap_len: got %0d want %0d", rx_q.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    for (int i = 0; i < exp_a.size() && i + 1 < addr_q.size(); i++) begin
      checks++; if (addr_q[i+1] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_q[i+1], exp_a[i]); end
    end
  endtask

  task automatic test_start_held();
    int d0;
    int n;
    bit ok;
    n = 2;
`ifdef STREAM_CHECKSUM_EN
    n = 3;
`endif
    rx_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    bus.base_addr_i = 12'h010;
    bus.len_i       = 13'd1;
    bus.start_i     = 1'b1;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_done_timeout: got none want done_o"); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL held_one_frame: got %0d want 1", done_cnt - d0); end
    checks++; if (rx_q.size() != n) begin errors++; $display("FAIL held_len: got %0d want %0d", rx_q.size(), n); end
    if (rx_q.size() > 1) begin
      checks++; if (rx_q[1] !== 8'h54) begin errors++; $display("FAIL held_payload: got %h want 54", rx_q[1]); end
    end
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL held_idle_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.tx_start_o !== 1'b0) begin errors++; $display("FAIL held_idle_start: got %b want 0", bus.tx_start_o); end
    @(negedge clk);
    checks++; if (bus.tx_start_o !== 1'b1) begin errors++; $display("FAIL held_second_hdr: got %b want 1", bus.tx_start_o); end
    bus.start_i = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_done2_timeout: got none want done_o"); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL held_two_frames: got %0d want 2", done_cnt - d0); end
    checks++; if (rx_q.size() != 2 * n) begin errors++; $display("FAIL held_len2: got %0d want %0d", rx_q.size(), 2 * n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [$];
    int d0;
    bit ok;
    exp_b = {8'hA5, 8'h54, 8'hFF, 8'h01};
`ifdef STREAM_CHECKSUM_EN
    exp_b.push_back(8'hAA);
`endif
    rx_q.delete();
    d0 = done_cnt;
    start_frame(12'h010, 13'd3);
    for (int i = 0; i < 2000 && rx_q.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    checks++; if (rx_q.size() < 3) begin errors++; $display("FAIL rstmid_reach: got %0d bytes want 3", rx_q.size()); end
    rst     = 1'b1;
    pending = 0;
    @(negedge clk);
    checks++; if (bus.tx_start_o !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b want 0", bus.tx_start_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.tx_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", bus.tx_data_o); end
    checks++; if (bus.bram_addr_o !== 12'h000) begin errors++; $display("FAIL rstmid_addr: got %h want 000", bus.bram_addr_o); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b want 0", bus.busy_o); end
    rx_q.delete();
    start_frame(12'h010, 13'd3);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_done_timeout: got none want done_o"); end
    checks++; if (rx_q.size() != exp_b.size()) begin errors++; $display("FAIL rstmid_len: got %0d want %0d", rx_q.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_latency();
    int c0;
    int t1;
    int t4;
    logic [7:0] d1;
    logic [7:0] d4;
    t1 = -1;
    t4 = -1;
    d1 = '0;
    d4 = '0;
    @(negedge clk);
    x_base  = 12'h123;
    x_len   = 13'd1;
    x_start = 1'b1;
    @(negedge clk);
    x_start = 1'b0;
    checks++; if (bus1.tx_start_o !== 1'b1) begin errors++; $display("FAIL lat1_hdr_start: got %b want 1", bus1.tx_start_o); end
    checks++; if (bus4.tx_start_o !== 1'b1) begin errors++; $display("FAIL lat4_hdr_start: got %b want 1", bus4.tx_start_o); end
    @(negedge clk);
    x_done = 1'b1;
    c0     = cyc;
    // held for a second cycle: the extra pulse lands in FETCH
    @(negedge clk);
    @(negedge clk);
    x_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus1.tx_start_o === 1'b1 && t1 < 0) begin t1 = cyc - c0; d1 = bus1.tx_data_o; end
      if (bus4.tx_start_o === 1'b1 && t4 < 0) begin t4 = cyc - c0; d4 = bus4.tx_data_o; end
      @(negedge clk);
    end
    checks++; if (t1 != 3) begin errors++; $display("FAIL lat1_start_delay: got %0d want 3", t1); end
    checks++; if (t4 != 6) begin errors++; $display("FAIL lat4_start_delay: got %0d want 6", t4); end
    checks++; if (d1 !== 8'h1F) begin errors++; $display("FAIL lat1_data: got %h want 1f", d1); end
    checks++; if (d4 !== 8'h1F) begin errors++; $display("FAIL lat4_data: got %h want 1f", d4); end
    x_done = 1'b1;
    @(negedge clk);
    x_done = 1'b0;
`ifdef STREAM_CHECKSUM_EN
    checks++; if (bus1.tx_start_o !== 1'b1 || bus1.tx_data_o !== 8'h1F) begin errors++; $display("FAIL lat1_ck: got %b/%h want 1/1f", bus1.tx_start_o, bus1.tx_data_o); end
    checks++; if (bus4.tx_start_o !== 1'b1 || bus4.tx_data_o !== 8'h1F) begin errors++; $display("FAIL lat4_ck: got %b/%h want 1/1f", bus4.tx_start_o, bus4.tx_data_o); end
    @(negedge clk);
    x_done = 1'b1;
    @(negedge clk);
    x_done = 1'b0;
`endif
    checks++; if (bus1.done_o !== 1'b1) begin errors++; $display("FAIL lat1_done: got %b want 1", bus1.done_o); end
    checks++; if (bus4.done_o !== 1'b1) begin errors++; $display("FAIL lat4_done: got %b want 1", bus4.done_o); end
    @(negedge clk);
    checks++; if (bus1.done_o !== 1'b0 || bus1.busy_o !== 1'b0) begin errors++; $display("FAIL lat1_idle: got %b/%b want 0/0", bus1.done_o, bus1.busy_o); end
    checks++; if (bus4.done_o !== 1'b0 || bus4.busy_o !== 1'b0) begin errors++; $display("FAIL lat4_idle: got %b/%b want 0/0", bus4.done_o, bus4.busy_o); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h54;
    mem[12'h011] = 8'hFF;
    mem[12'h012] = 8'h01;
    mem[12'hFFE] = 8'h11;
    mem[12'hFFF] = 8'h22;
    mem[12'h000] = 8'h33;
    mem[12'h001] = 8'h44;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i       = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_len_zero();
    test_wrap();
    test_start_held();
    test_reset_mid();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
